nco_chk_monitor: RTL

- Synthesizable, multi-channel protocol monitor for NCO outputs; the parametrised successor to the single-channel NCO assertion set.
- Per channel it checks three rules: wave output is zero after reset, waveform select is held for a minimum time, and the wave output responds to a select change.
- Violations are reported as sticky per-channel flags, a saturating error counter and a first-error capture record.
- Sits beside the NCO array in silicon and in emulation; the flags are readable by software.

---
 rtl/nco_chk_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/nco_chk_monitor.sv
// nco_chk_monitor: multi-channel protocol monitor for NCO outputs.
// Checks per channel: wave is zero right after reset, the select is held
// for a minimum window after each change, and the wave responds to each
// select change RESP_LATENCY cycles later. Violations become sticky flags,
// a saturating counter and a first-error record.
// Optional macro NCO_CHK_TIMESTAMP_EN adds a 32-bit cycle stamp to the
// first-error record; without it first_err_time reads 0.
// Per-channel FSM state is held in state_q[] so checkers can bind to it.
module nco_chk_monitor #(
  parameter int NUM_CH       = 4,
  parameter int SELECT_WIDTH = 2,
  parameter int WAVE_WIDTH   = 8,
  parameter int HOLD_CYCLES  = 31,
  parameter int RESP_LATENCY = 1,
  parameter int CNT_WIDTH    = 16,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              chan_en,
  input  logic [NUM_CH*SELECT_WIDTH-1:0] signal_out,
  input  logic [NUM_CH*WAVE_WIDTH-1:0]   wave_out,
  input  logic                           clr_err,
  output logic [NUM_CH-1:0]              err_rst,
  output logic [NUM_CH-1:0]              err_hold,
  output logic [NUM_CH-1:0]              err_resp,
  output logic [CNT_WIDTH-1:0]           err_count,
  output logic                           first_err_valid,
  output logic [CHW-1:0]                 first_err_ch,
  output logic [1:0]                     first_err_code,
  output logic [31:0]                    first_err_time
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [7:0] HOLD_LD  = HOLD_CYCLES[7:0];

  logic [1:0]              state_q     [NUM_CH];
  logic [7:0]              cnt_q       [NUM_CH];
  logic [SELECT_WIDTH-1:0] prev_sel_q  [NUM_CH];
  logic [WAVE_WIDTH-1:0]   prev_wave_q [NUM_CH];
  logic [RESP_LATENCY-1:0] dl_q        [NUM_CH];
  logic                    post_rst_q;

  logic [1:0]              state_n [NUM_CH];
  logic [7:0]              cnt_n   [NUM_CH];
  logic [RESP_LATENCY-1:0] dl_n    [NUM_CH];
  logic [NUM_CH-1:0]       v_rst, v_hold, v_resp;
  logic                    any_v;
  logic [CHW-1:0]          fe_ch;
  logic [1:0]              fe_code;

  // Per-channel change detection, violation decode and FSM next state.
  always_comb begin
    v_rst  = '0;
    v_hold = '0;
    v_resp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic [SELECT_WIDTH-1:0] sel;
      logic [WAVE_WIDTH-1:0]   wav;
      logic                    active;
      logic                    chg;
      sel    = signal_out[i*SELECT_WIDTH +: SELECT_WIDTH];
      wav    = wave_out[i*WAVE_WIDTH +: WAVE_WIDTH];
      active = chan_en[i] && (state_q[i] != ST_IDLE);
      chg    = active && (sel != prev_sel_q[i]);
      v_rst[i]  = post_rst_q && chan_en[i] && (wav != '0);
      v_hold[i] = (state_q[i] == ST_HOLD) && chg;
      v_resp[i] = active && dl_q[i][RESP_LATENCY-1] && (wav == prev_wave_q[i]);
      dl_n[i]    = dl_q[i] << 1;
      dl_n[i][0] = chg;
      state_n[i] = state_q[i];
      cnt_n[i]   = cnt_q[i];
      if (!chan_en[i]) begin
        state_n[i] = ST_IDLE;
        cnt_n[i]   = '0;
        dl_n[i]    = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: state_n[i] = ST_ARMED;
          ST_ARMED: begin
            if (chg) begin
              state_n[i] = ST_HOLD;
              cnt_n[i]   = HOLD_LD;
            end
          end
          ST_HOLD: begin
            if (chg) begin
              cnt_n[i] = HOLD_LD;
            end else if (cnt_q[i] <= 8'd1) begin
              state_n[i] = ST_ARMED;
              cnt_n[i]   = '0;
            end else begin
              cnt_n[i] = cnt_q[i] - 8'd1;
            end
          end
          default: begin
            state_n[i] = ST_IDLE;
            cnt_n[i]   = '0;
          end
        endcase
      end
    end
  end

  // First-error selection: scan high to low so the lowest channel wins,
  // and within a channel reset overrides hold overrides response.
  always_comb begin
    fe_ch   = '0;
    fe_code = 2'b00;
    any_v   = |(v_rst | v_hold | v_resp);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v_resp[i]) begin fe_ch = i[CHW-1:0]; fe_code = 2'b11; end
      if (v_hold[i]) begin fe_ch = i[CHW-1:0]; fe_code = 2'b10; end
      if (v_rst[i])  begin fe_ch = i[CHW-1:0]; fe_code = 2'b01; end
    end
  end

  // Channel state, hold counters, delay lines and previous-sample registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      post_rst_q <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]     <= ST_IDLE;
        cnt_q[i]       <= '0;
        dl_q[i]        <= '0;
        prev_sel_q[i]  <= '0;
        prev_wave_q[i] <= '0;
      end
    end else begin
      post_rst_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]     <= state_n[i];
        cnt_q[i]       <= cnt_n[i];
        dl_q[i]        <= dl_n[i];
        prev_sel_q[i]  <= signal_out[i*SELECT_WIDTH +: SELECT_WIDTH];
        prev_wave_q[i] <= wave_out[i*WAVE_WIDTH +: WAVE_WIDTH];
      end
    end
  end

`ifdef NCO_CHK_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] time_q;

  // Free-running cycle stamp and its first-error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q   <= '0;
      time_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (any_v && (clr_err || !first_err_valid)) time_q <= ts_q;
      else if (clr_err)                           time_q <= '0;
    end
  end

  assign first_err_time = time_q;
`else
  assign first_err_time = 32'd0;
`endif

  // Error reporting: clear applies first, then this cycle's violations.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_rst         <= '0;
      err_hold        <= '0;
      err_resp        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_code  <= 2'b00;
    end else begin
      err_rst  <= (clr_err ? '0 : err_rst)  | v_rst;
      err_hold <= (clr_err ? '0 : err_hold) | v_hold;
      err_resp <= (clr_err ? '0 : err_resp) | v_resp;
      if (clr_err) begin
        err_count <= any_v ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
      end else if (any_v && (err_count != {CNT_WIDTH{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
      if (any_v && (clr_err || !first_err_valid)) begin
        first_err_valid <= 1'b1;
        first_err_ch    <= fe_ch;
        first_err_code  <= fe_code;
      end else if (clr_err) begin
        first_err_valid <= 1'b0;
        first_err_ch    <= '0;
        first_err_code  <= 2'b00;
      end
    end
  end

endmodule
